// File: rtl/coef_rom_sequencer_pkg.sv
// Shared types for the coefficient ROM sequencer: ROM geometry, sequencer
// state encoding and the skid-buffer entry layout.
package coef_rom_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [ROM_DATA_W-1:0] data;
        logic [ROM_ADDR_W-1:0] idx;
        logic                  last;
    } coef_entry_t;

endpackage

// File: rtl/coef_rom_sequencer_skid_fifo.sv
// Two-entry synchronous FIFO of coefficient entries; flush empties it in one
// cycle and overrides push/pop.
module coef_skid_fifo
    import coef_rom_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  coef_entry_t push_entry,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  occ,
    output coef_entry_t head
);

    coef_entry_t mem_q [2];
    coef_entry_t mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = '0;
        end else begin
            // On a full buffer with push and pop, the write lands in the slot
            // being popped; the head is read from mem_q, so no hazard.
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/coef_rom_sequencer.sv
// Streams a contiguous, wrapping run of pROM coefficient words to the filter
// datapath over valid/ready, with credit-based issue into a 2-entry skid buffer.
module coef_rom_sequencer
    import coef_rom_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] coef_data,
    output logic [ADDR_W-1:0] coef_idx,
    output logic              coef_last,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pend_idx_q, pend_idx_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic              flush;
    logic [2:0]        credit_used;
    logic [1:0]        occ;
    coef_entry_t       head;
    coef_entry_t       push_entry;

    coef_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .occ        (occ),
        .head       (head)
    );

    assign coef_valid = (occ != 2'd0);
    assign pop        = coef_valid & coef_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        pend_idx_d  = pend_idx_q;
        issue       = 1'b0;
        push        = ce_q;
        flush       = 1'b0;
        // Buffered words plus the read in flight, less the word leaving now.
        credit_used = {1'b0, occ} + {2'b00, ce_q} - {2'b00, pop};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    base_d   = base_addr;
                    len_d    = (len == '0) ? FULL_LEN : {1'b0, len};
                    issued_d = '0;
                end
            end
            RUN: begin
                if ((issued_q < len_q) && (credit_used < 3'(BUF_DEPTH))) begin
                    issue      = 1'b1;
                    issued_d   = issued_q + CNT_ONE;
                    pend_idx_d = issued_q[ADDR_W-1:0];
                end
                if (pop && head.last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort || !rst_n) begin
            state_d = IDLE;
            issue   = 1'b0;
            push    = 1'b0;
            flush   = 1'b1;
        end
        ce_d = issue;
    end

    always_comb begin
        push_entry      = '0;
        push_entry.data = rom_dout;
        push_entry.idx  = pend_idx_q;
        push_entry.last = ({1'b0, pend_idx_q} == (len_q - CNT_ONE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            ce_q       <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            ce_q       <= ce_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign coef_data = coef_valid ? head.data : '0;
    assign coef_idx  = coef_valid ? head.idx  : '0;
    assign coef_last = coef_valid & head.last;
    assign rom_ce    = issue;
    assign rom_ad    = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
    assign rom_oce   = 1'b1;
    assign rom_reset = ~rst_n;

endmodule

// File: tb/tb_coef_rom_sequencer.sv
// Directed and randomized checks of the coefficient ROM sequencer against a
// queue-based model of the expected word stream.
module tb_coef_rom_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [3:0]  len = '0;
    logic        abort = 1'b0;
    logic        coef_ready = 1'b0;
    logic        busy, done, coef_last, coef_valid;
    logic [31:0] coef_data;
    logic [3:0]  coef_idx;
    logic        rom_ce, rom_oce, rom_reset;
    logic [3:0]  rom_ad;
    logic [31:0] rom_dout;
    logic [31:0] rom [16];

    always #5 clk = ~clk;

    coef_rom_sequencer #(.ADDR_W(4), .DATA_W(32), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .coef_data  (coef_data),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .rom_ce     (rom_ce),
        .rom_oce    (rom_oce),
        .rom_reset  (rom_reset),
        .rom_ad     (rom_ad),
        .rom_dout   (rom_dout)
    );

    // pROM behavioural model: registered read, synchronous active-high reset
    always @(posedge clk) begin
        if (rom_reset) rom_dout <= '0;
        else if (rom_ce) rom_dout <= rom[rom_ad];
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic       m_busy = 1'b0;
    logic       m_done_due = 1'b0;
    int         n_issued = 0, n_popped = 0, run_len = 0;
    logic [3:0] run_base = '0;
    int         passed = 0, total = 0, cyc = 0;
    int         done_seen = 0;
    int         start_cyc = 0, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
    logic       pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    endtask

    task automatic observe();
        logic       kill, accept, pop_now, popped_last, nrst, credit_ok;
        logic [3:0] ad_exp;
        exp_t       h;
        nrst        = ~rst_n;
        kill        = !rst_n || abort;
        accept      = start && !m_busy;
        pop_now     = coef_valid && coef_ready;
        popped_last = 1'b0;
        check("rom_oce", rom_oce, 1'b1);
        check("rom_reset", rom_reset, nrst);
        check("busy", busy, m_busy);
        check("done", done, m_done_due);
        if (done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
            check("no_spurious_valid", coef_valid, 1'b0);
        end else if (coef_valid === 1'b1) begin
            h = exp_q[0];
            check("coef_data", coef_data, h.data);
            check("coef_idx", coef_idx, h.idx);
            check("coef_last", coef_last, h.last);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (kill) check("rom_ce_killed", rom_ce, 1'b0);
        if (rom_ce === 1'b1) begin
            ad_exp    = run_base + n_issued[3:0];
            credit_ok = ((n_issued - n_popped - int'(pop_now)) < 2) && (n_issued < run_len);
            check("rom_ad", rom_ad, ad_exp);
            check("rom_ce_credit", credit_ok, 1'b1);
            n_issued++;
        end
        if (pop_now && exp_q.size() > 0) begin
            popped_last = exp_q[0].last;
            void'(exp_q.pop_front());
            n_popped++;
            if (popped_last) last_hs_cyc = cyc;
        end
        if (kill) begin
            m_busy     = 1'b0;
            m_done_due = 1'b0;
            exp_q.delete();
        end else begin
            if (m_done_due) m_busy = 1'b0;
            m_done_due = popped_last;
            if (accept) begin
                m_busy          = 1'b1;
                run_base        = base_addr;
                run_len         = (len == 4'd0) ? 16 : int'(len);
                n_issued        = 0;
                n_popped        = 0;
                start_cyc       = cyc;
                first_valid_cyc = -1;
                exp_q.delete();
                for (int i = 0; i < run_len; i++) begin
                    logic [3:0] a;
                    exp_t       e;
                    a      = base_addr + 4'(i);
                    e.data = rom[a];
                    e.idx  = 4'(i);
                    e.last = (i == run_len - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic i_rst_n, input logic i_start, input logic [3:0] i_base,
                        input logic [3:0] i_len, input logic i_abort, input logic i_ready);
        @(posedge clk);
        #1;
        cyc++;
        rst_n      = i_rst_n;
        start      = i_start;
        base_addr  = i_base;
        len        = i_len;
        abort      = i_abort;
        coef_ready = i_ready;
        #1;
        observe();
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, rdy);
    endtask

    // mode 0: ready held high, 1: 1,0,0,1,0 repeating, 2: random
    task automatic run_out(input int mode, input int budget);
        int   k;
        logic rdy;
        logic timed_out;
        k = 0;
        while (m_busy && k < budget) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[k % 5];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            idle(rdy);
            k++;
        end
        timed_out = m_busy;
        check("run_timeout", timed_out, 1'b0);
    endtask

    initial begin
        int d0, rel;
        for (int i = 0; i < 16; i++) rom[i] = 32'hC0DE_0000 + 32'(i);

        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        idle(1'b0);
        check("reset_coef_data", coef_data, 32'd0);
        check("reset_coef_idx", coef_idx, 4'd0);
        check("reset_rom_ad", rom_ad, 4'd0);
        check("reset_rom_ce", rom_ce, 1'b0);

        // Basic run: base 2, len 9, ready high
        d0 = done_seen;
        step(1'b1, 1'b1, 4'd2, 4'd9, 1'b0, 1'b1);
        run_out(0, 40);
        rel = first_valid_cyc - start_cyc;
        check("basic_first_valid_cycle", rel, 3);
        rel = last_hs_cyc - start_cyc;
        check("basic_last_hs_cycle", rel, 11);
        rel = done_cyc - start_cyc;
        check("basic_done_cycle", rel, 12);
        rel = done_seen - d0;
        check("basic_done_count", rel, 1);
        idle(1'b1);

        // Wrap with len 0 (16 words from 14)
        d0 = done_seen;
        step(1'b1, 1'b1, 4'd14, 4'd0, 1'b0, 1'b1);
        run_out(0, 60);
        check("wrap_words", n_popped, 16);
        rel = done_cyc - start_cyc;
        check("wrap_done_cycle", rel, 19);
        rel = done_seen - d0;
        check("wrap_done_count", rel, 1);
        idle(1'b0);

        // Backpressure
        d0 = done_seen;
        step(1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b1);
        run_out(1, 80);
        check("bp_words", n_popped, 5);
        rel = done_seen - d0;
        check("bp_done_count", rel, 1);
        idle(1'b0);

        // Abort in cycle 5 of a len 9 run, then a len 1 run from 3
        d0 = done_seen;
        step(1'b1, 1'b1, 4'd0, 4'd9, 1'b0, 1'b1);
        repeat (4) idle(1'b1);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        idle(1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", coef_valid, 1'b0);
        repeat (3) idle(1'b1);
        rel = done_seen - d0;
        check("abort_no_done", rel, 0);
        step(1'b1, 1'b1, 4'd3, 4'd1, 1'b0, 1'b1);
        run_out(0, 20);
        check("after_abort_words", n_popped, 1);
        rel = done_seen - d0;
        check("after_abort_done_count", rel, 1);

        // Abort coinciding with start: start dropped
        step(1'b1, 1'b1, 4'd7, 4'd4, 1'b1, 1'b1);
        idle(1'b1);
        check("abort_start_busy", busy, 1'b0);

        // Second start while busy is ignored
        d0 = done_seen;
        step(1'b1, 1'b1, 4'd1, 4'd6, 1'b0, 1'b1);
        repeat (3) idle(1'b1);
        step(1'b1, 1'b1, 4'd9, 4'd2, 1'b0, 1'b1);
        run_out(0, 40);
        check("ignored_start_words", n_popped, 6);
        rel = done_seen - d0;
        check("ignored_start_done_count", rel, 1);
        repeat (3) idle(1'b1);

        // Synchronous reset mid-run
        step(1'b1, 1'b1, 4'd5, 4'd10, 1'b0, 1'b0);
        repeat (4) idle(1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        idle(1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", coef_valid, 1'b0);
        check("rst_last", coef_last, 1'b0);
        check("rst_idx", coef_idx, 4'd0);
        check("rst_data", coef_data, 32'd0);
        check("rst_rom_ce", rom_ce, 1'b0);
        check("rst_rom_ad", rom_ad, 4'd0);

        // Randomized ROM contents, runs and backpressure
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        for (int r = 0; r < 8; r++) begin
            logic [3:0] b, l;
            int         want;
            b    = 4'($urandom_range(0, 15));
            l    = 4'($urandom_range(0, 15));
            want = (l == 4'd0) ? 16 : int'(l);
            d0   = done_seen;
            step(1'b1, 1'b1, b, l, 1'b0, 1'($urandom_range(0, 1)));
            run_out(2, 200);
            check("rand_words", n_popped, want);
            rel = done_seen - d0;
            check("rand_done_count", rel, 1);
            repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
